// File: rtl/bcd_countdown99_if.sv
// Control and status bundle for the two-digit BCD countdown timer.
// Ports: ce_i, load_i, preset_i[7:0], start_i, stop_i (to the counter);
//        cnt_o[7:0], dn_o, busy_o, done_o (from the counter).
interface bcd_countdown99_if;
   logic       ce_i;
   logic       load_i;
   logic [7:0] preset_i;
   logic       start_i;
   logic       stop_i;
   logic [7:0] cnt_o;
   logic       dn_o;
   logic       busy_o;
   logic       done_o;

   // Counter side.
   modport slave (
      input  ce_i, load_i, preset_i, start_i, stop_i,
      output cnt_o, dn_o, busy_o, done_o
   );

   // Controller side.
   modport master (
      output ce_i, load_i, preset_i, start_i, stop_i,
      input  cnt_o, dn_o, busy_o, done_o
   );
endinterface

// File: rtl/bcd_countdown99.sv
// Two-digit BCD countdown timer (99..00) with LOAD/START/STOP control and a
// combinational terminal-borrow pulse (dn_o) for cascading further stages.
// Ports: clk_i, rst_i (async, active-high), bus (bcd_countdown99_if.slave).
// Option: define BCD_COUNTDOWN_AUTORELOAD_EN to reload and keep running on the
//         terminal tick instead of stopping in DONE.
module bcd_countdown99 #(
   parameter logic [7:0] INIT_PRESET = 8'h59
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   bcd_countdown99_if.slave      bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t     state_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] cnt_q,    cnt_d;
   logic [7:0] reload_q, reload_d;

   logic [7:0] preset_clamped;
   logic       terminal;
   logic       ce_acc;
   logic       start_acc;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   assign preset_clamped = {clamp_digit(bus.preset_i[7:4]), clamp_digit(bus.preset_i[3:0])};
   assign terminal       = (cnt_q == 8'h00);

   // LOAD and STOP both outrank CE; STOP only matters in RUN, and START is a
   // no-op in RUN, so START never masks a tick there.
   assign ce_acc    = (state_q == ST_RUN) && bus.ce_i && !bus.load_i && !bus.stop_i;
   assign start_acc = bus.start_i && !bus.load_i && (state_q != ST_RUN);

   // Datapath: count and reload registers.
   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      if (bus.load_i) begin
         cnt_d    = preset_clamped;
         reload_d = preset_clamped;
      end else if (start_acc && (state_q == ST_DONE)) begin
         cnt_d = reload_q;
      end else if (ce_acc) begin
         if (terminal) begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            cnt_d = reload_q;
`else
            cnt_d = cnt_q;
`endif
         end else if (cnt_q[3:0] == 4'd0) begin
            // Borrow from the tens digit; ones wrap to 9.
            cnt_d = {cnt_q[7:4] - 4'd1, 4'd9};
         end else begin
            cnt_d = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q    <= INIT_PRESET;
         reload_q <= INIT_PRESET;
      end else begin
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
      end
   end

   // Control FSM with registered status flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.load_i) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (bus.start_i) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (bus.stop_i) begin
                  state_q <= ST_HOLD;
                  busy_q  <= 1'b0;
               end else if (ce_acc && terminal) begin
`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
               end
            end
            ST_DONE: begin
               if (bus.start_i) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cnt_o  = cnt_q;
   assign bus.dn_o   = ce_acc && terminal;
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;

endmodule

// File: tb/tb_bcd_countdown99.sv
// Testbench for bcd_countdown99: vector table applied cycle by cycle with
// expected results queued at drive time and checked after the clock edge.
module tb_bcd_countdown99;

   logic clk;
   logic rst;

   bcd_countdown99_if bus ();

   bcd_countdown99 #(.INIT_PRESET(8'h59)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       load;
      logic [7:0] preset;
      logic       start;
      logic       stop;
      logic       ce;
      logic       dn;
      logic [7:0] cnt;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [7:0] bcd(input int v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   function automatic void add(input logic ld, input logic [7:0] p, input logic st,
                               input logic sp, input logic c, input logic e_dn,
                               input logic [7:0] e_cnt, input logic e_busy,
                               input logic e_done);
      vec_t v;
      v.load = ld; v.preset = p; v.start = st; v.stop = sp; v.ce = c;
      v.dn = e_dn; v.cnt = e_cnt; v.busy = e_busy; v.done = e_done;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.ce_i = 1'b0; bus.load_i = 1'b0; bus.preset_i = 8'h00;
      bus.start_i = 1'b0; bus.stop_i = 1'b0;
   endtask

   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      logic dn_seen;
      @(negedge clk);
      bus.load_i = v.load; bus.preset_i = v.preset; bus.start_i = v.start;
      bus.stop_i = v.stop; bus.ce_i = v.ce;
      sb.push_back(v);
      #1 dn_seen = bus.dn_o;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("dn",   idx, {7'd0, dn_seen},     {7'd0, e.dn});
      chk("cnt",  idx, bus.cnt_o,           e.cnt);
      chk("busy", idx, {7'd0, bus.busy_o},  {7'd0, e.busy});
      chk("done", idx, {7'd0, bus.done_o},  {7'd0, e.done});
   endtask

   task automatic check_reset_vals(input int idx);
      chk("rst_cnt",  idx, bus.cnt_o,          8'h59);
      chk("rst_busy", idx, {7'd0, bus.busy_o}, 8'h00);
      chk("rst_done", idx, {7'd0, bus.done_o}, 8'h00);
      chk("rst_dn",   idx, {7'd0, bus.dn_o},   8'h00);
   endtask

   initial begin
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 check_reset_vals(-1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check_reset_vals(-2);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
      // Periodic mode: preset 02 gives a period of 3 ticks.
      add(1, 8'h02, 0, 0, 0, 0, 8'h02, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h02, 1, 0);
      for (int k = 1; k <= 9; k++)
         add(0, 8'h00, 0, 0, 1, (k % 3 == 0), bcd(2 - (k % 3) + ((k % 3 == 0) ? 0 : 0)) , 1, 0);
      // Leave RUN at 07 for the reset sequence.
      add(1, 8'h07, 0, 0, 0, 0, 8'h07, 0, 0);
      add(0, 8'h00, 1, 0, 1, 0, 8'h07, 1, 0);
`else
      // LOAD 12, START, 13 ticks down to 00 then terminal.
      add(1, 8'h12, 0, 0, 0, 0, 8'h12, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h12, 1, 0);
      for (int k = 1; k <= 12; k++)
         add(0, 8'h00, 0, 0, 1, 0, bcd(12 - k), 1, 0);
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 1);
      // CE in DONE is ignored.
      add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1);
      // Clamp and cross-digit borrow.
      add(1, 8'hAF, 0, 0, 0, 0, 8'h99, 0, 0);
      add(1, 8'h10, 0, 0, 0, 0, 8'h10, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h10, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h09, 1, 0);
      // STOP beats CE; HOLD freezes; resume.
      add(1, 8'h05, 0, 0, 0, 0, 8'h05, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h05, 1, 0);
      add(0, 8'h00, 0, 1, 1, 0, 8'h05, 0, 0);
      for (int k = 0; k < 3; k++)
         add(0, 8'h00, 0, 0, 1, 0, 8'h05, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h05, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h04, 1, 0);
      // At 00: CE+STOP gives no borrow; resume; terminal on preset 00.
      add(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 1);
      // Preset 03: four ticks, borrow on the fourth; START from DONE reloads.
      add(1, 8'h03, 0, 0, 0, 0, 8'h03, 0, 0);
      add(0, 8'h00, 1, 0, 0, 0, 8'h03, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h02, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h01, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0);
      add(0, 8'h00, 0, 0, 1, 1, 8'h00, 0, 1);
      add(0, 8'h00, 1, 0, 0, 0, 8'h03, 1, 0);
      add(0, 8'h00, 0, 0, 1, 0, 8'h02, 1, 0);
      // LOAD in RUN with CE: LOAD wins, ones nibble clamped.
      add(1, 8'h3B, 0, 0, 1, 0, 8'h39, 0, 0);
      // START+CE in IDLE: CE ignored.
      add(0, 8'h00, 1, 0, 1, 0, 8'h39, 1, 0);
      // Park in RUN at 07 for the reset sequence.
      add(1, 8'h07, 0, 0, 0, 0, 8'h07, 0, 0);
      add(0, 8'h00, 1, 0, 1, 0, 8'h07, 1, 0);
`endif

      for (int i = 0; i < vecs.size(); i++)
         apply(i, vecs[i]);

      // Asynchronous reset in the middle of a cycle while a tick is pending.
      @(negedge clk);
      drive_idle();
      bus.ce_i = 1'b1;
      #2 rst = 1'b1;
      #1 check_reset_vals(1000);
      @(posedge clk);
      #1 check_reset_vals(1001);
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      // After reset the counter is IDLE: a tick must not move it.
      begin
         vec_t v;
         v.load = 0; v.preset = 8'h00; v.start = 0; v.stop = 0; v.ce = 1;
         v.dn = 0; v.cnt = 8'h59; v.busy = 0; v.done = 0;
         apply(1002, v);
      end

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, expected end");
      $fatal(1, "timeout");
   end

endmodule
